hc112_seq_ctrl: RTL and testbench

HC112_SEQ_CTRL -- requirements
Module: hc112_seq_ctrl

---
 rtl/hc112_seq_pkg.sv | 23 ++
 rtl/hc112_jk_gen.sv | 38 +++
 rtl/hc112_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_hc112_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc112_seq_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the HC112 pair sequencer.
package hc112_seq_pkg;

  localparam int CNT_W_DEFAULT = 8;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_PRESET = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_CNT_UP = 3'd5;
  localparam logic [2:0] OP_CNT_DN = 3'd6;
  localparam logic [2:0] OP_VERIFY = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ASYNC = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/hc112_jk_gen.sv
// Combinational J/K drive for one RUN cycle of the HC112 pair, given op, mask, arg and live Q.
module hc112_jk_gen
  import hc112_seq_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic [1:2] i_mask,
  input  logic [1:2] i_arg,
  input  logic [1:2] i_q,
  output logic [1:2] o_j,
  output logic [1:2] o_k
);

  // Counting: flop 2 always toggles; flop 1 toggles when flop 2 is about to carry (up) or borrow (down).
  always_comb begin
    o_j = 2'b00;
    o_k = 2'b00;
    case (i_op)
      OP_LOAD: begin
        o_j = i_arg;
        o_k = ~i_arg;
      end
      OP_TOGGLE: begin
        o_j = i_mask;
        o_k = i_mask;
      end
      OP_CNT_UP: begin
        o_j = {i_q[2], 1'b1};
        o_k = {i_q[2], 1'b1};
      end
      OP_CNT_DN: begin
        o_j = {~i_q[2], 1'b1};
        o_k = {~i_q[2], 1'b1};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hc112_seq_ctrl.sv
// Command sequencer driving an external HC112 dual J-K flip-flop pair with registered J/K/SD/RD.
module hc112_seq_ctrl
  import hc112_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             Clk,
  input  logic             RD,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:2]       cmd_mask,
  input  logic [1:2]       cmd_arg,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [1:2]       Q,
  output logic [1:2]       J,
  output logic [1:2]       K,
  output logic [1:2]       SD_o,
  output logic [1:2]       RD_o,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  state_t           r_state;
  logic [2:0]       r_op;
  logic [1:2]       r_mask;
  logic [1:2]       r_arg;
  logic [CNT_W-1:0] r_cnt;
  logic [1:2]       r_j, r_k, r_sd, r_rd;
  logic             r_done, r_err;

  state_t           w_stateNext;
  logic [CNT_W-1:0] w_cntNext;
  logic [1:2]       w_jNext, w_kNext, w_sdNext, w_rdNext;
  logic             w_doneNext, w_errSet, w_accept;
  logic [2:0]       w_genOp;
  logic [1:2]       w_genMask, w_genArg, w_genJ, w_genK;

  assign w_accept  = cmd_valid && (r_state == ST_IDLE);
  // The first RUN cycle's J/K is registered on the accept edge, before the command is latched.
  assign w_genOp   = (r_state == ST_IDLE) ? cmd_op   : r_op;
  assign w_genMask = (r_state == ST_IDLE) ? cmd_mask : r_mask;
  assign w_genArg  = (r_state == ST_IDLE) ? cmd_arg  : r_arg;

  hc112_jk_gen u_jk_gen (
    .i_op   (w_genOp),
    .i_mask (w_genMask),
    .i_arg  (w_genArg),
    .i_q    (Q),
    .o_j    (w_genJ),
    .o_k    (w_genK)
  );

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_jNext     = 2'b00;
    w_kNext     = 2'b00;
    w_sdNext    = 2'b11;
    w_rdNext    = 2'b11;
    w_doneNext  = 1'b0;
    w_errSet    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP: begin
              w_stateNext = ST_DONE;
              w_doneNext  = 1'b1;
            end
            OP_CLEAR: begin
              w_stateNext = ST_ASYNC;
              w_rdNext    = ~cmd_mask;
            end
            OP_PRESET: begin
              w_stateNext = ST_ASYNC;
              w_sdNext    = ~cmd_mask;
            end
            OP_LOAD: begin
              w_stateNext = ST_RUN;
              w_cntNext   = CNT_W'(1);
              w_jNext     = w_genJ;
              w_kNext     = w_genK;
            end
            OP_TOGGLE, OP_CNT_UP, OP_CNT_DN: begin
              if (cmd_cnt == '0) begin
                w_stateNext = ST_DONE;
                w_doneNext  = 1'b1;
              end else begin
                w_stateNext = ST_RUN;
                w_cntNext   = cmd_cnt;
                w_jNext     = w_genJ;
                w_kNext     = w_genK;
              end
            end
            OP_VERIFY: begin
              w_stateNext = ST_CHECK;
            end
          endcase
        end
      end
      ST_ASYNC: begin
        w_stateNext = ST_DONE;
        w_doneNext  = 1'b1;
      end
      ST_RUN: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_stateNext = ST_DONE;
          w_cntNext   = '0;
          w_doneNext  = 1'b1;
        end else begin
          w_cntNext = r_cnt - CNT_W'(1);
          w_jNext   = w_genJ;
          w_kNext   = w_genK;
        end
      end
      ST_CHECK: begin
        w_stateNext = ST_DONE;
        w_doneNext  = 1'b1;
        w_errSet    = (Q != r_arg);
      end
      ST_DONE: begin
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge RD) begin
    if (!RD) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NOP;
      r_mask  <= 2'b00;
      r_arg   <= 2'b00;
      r_cnt   <= '0;
      r_j     <= 2'b00;
      r_k     <= 2'b00;
      r_sd    <= 2'b11;
      r_rd    <= 2'b11;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_j     <= w_jNext;
      r_k     <= w_kNext;
      r_sd    <= w_sdNext;
      r_rd    <= w_rdNext;
      r_done  <= w_doneNext;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_mask <= cmd_mask;
        r_arg  <= cmd_arg;
      end
      // A mismatch detected in the same cycle as a clear request keeps the flag set.
      if (w_errSet) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign J         = r_j;
  assign K         = r_k;
  assign SD_o      = r_sd;
  assign RD_o      = r_rd;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_hc112_seq_ctrl.sv
// Directed bench for hc112_seq_ctrl driving a behavioural HC112 pair (falling-edge J-K, async SD/RD).
module tb_hc112_seq_ctrl;
  import hc112_seq_pkg::*;

  logic       Clk = 1'b0;
  logic       RD = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [1:2] cmd_mask = 2'b00;
  logic [1:2] cmd_arg = 2'b00;
  logic [7:0] cmd_cnt = 8'd0;
  logic [1:2] Q;
  logic [1:2] J, K, SD_o, RD_o;
  logic       cmd_ready, busy, done, err;
  logic       q1, q2;
  logic [1:2] upSeq [5];

  int checkCount = 0;
  int errorCount = 0;

  always #5 Clk = ~Clk;

  hc112_seq_ctrl #(.CNT_W(8)) dut (
    .Clk       (Clk),
    .RD        (RD),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_arg   (cmd_arg),
    .cmd_cnt   (cmd_cnt),
    .Q         (Q),
    .J         (J),
    .K         (K),
    .SD_o      (SD_o),
    .RD_o      (RD_o),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_clr   (err_clr)
  );

  assign Q = {q1, q2};

  // Model of the external HC112 pair: clear dominates preset, J/K sampled on the falling clock edge.
  always @(negedge Clk or negedge RD_o[1] or negedge SD_o[1]) begin
    if (!RD_o[1]) q1 <= 1'b0;
    else if (!SD_o[1]) q1 <= 1'b1;
    else case ({J[1], K[1]})
      2'b01: q1 <= 1'b0;
      2'b10: q1 <= 1'b1;
      2'b11: q1 <= ~q1;
      default: ;
    endcase
  end

  always @(negedge Clk or negedge RD_o[2] or negedge SD_o[2]) begin
    if (!RD_o[2]) q2 <= 1'b0;
    else if (!SD_o[2]) q2 <= 1'b1;
    else case ({J[2], K[2]})
      2'b01: q2 <= 1'b0;
      2'b10: q2 <= 1'b1;
      2'b11: q2 <= ~q2;
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [1:2] mask,
                               input logic [1:2] arg, input logic [7:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_arg   = arg;
    cmd_cnt   = cnt;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic clearPair();
    applyStimulus(OP_CLEAR, 2'b11, 2'b00, 8'd0);
    tick();
    tick();
  endtask

  initial begin
    upSeq = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};

    #2 RD = 1'b0;
    tick();
    tick();
    checkOutput("rst_ready", {1'b0, cmd_ready}, 2'b01);
    checkOutput("rst_busy",  {1'b0, busy}, 2'b00);
    checkOutput("rst_J",     J, 2'b00);
    checkOutput("rst_K",     K, 2'b00);
    checkOutput("rst_SD",    SD_o, 2'b11);
    checkOutput("rst_RD",    RD_o, 2'b11);
    checkOutput("rst_done",  {1'b0, done}, 2'b00);
    checkOutput("rst_err",   {1'b0, err}, 2'b00);
    RD = 1'b1;

    applyStimulus(OP_CLEAR, 2'b11, 2'b00, 8'd0);
    checkOutput("clr_RD_o",  RD_o, 2'b00);
    checkOutput("clr_SD_o",  SD_o, 2'b11);
    checkOutput("clr_Q",     Q, 2'b00);
    checkOutput("clr_busy",  {1'b0, busy}, 2'b01);
    checkOutput("clr_ready", {1'b0, cmd_ready}, 2'b00);
    checkOutput("clr_done0", {1'b0, done}, 2'b00);
    tick();
    checkOutput("clr_done1", {1'b0, done}, 2'b01);
    checkOutput("clr_RD_rel", RD_o, 2'b11);
    checkOutput("clr_Q_hold", Q, 2'b00);
    tick();
    checkOutput("clr_done2", {1'b0, done}, 2'b00);
    checkOutput("clr_idle",  {1'b0, cmd_ready}, 2'b01);

    applyStimulus(OP_LOAD, 2'b00, 2'b10, 8'd0);
    checkOutput("load_J", J, 2'b10);
    checkOutput("load_K", K, 2'b01);
    checkOutput("load_done0", {1'b0, done}, 2'b00);
    tick();
    checkOutput("load_Q", Q, 2'b10);
    checkOutput("load_J_end", J, 2'b00);
    checkOutput("load_K_end", K, 2'b00);
    checkOutput("load_done1", {1'b0, done}, 2'b01);
    tick();

    applyStimulus(OP_VERIFY, 2'b00, 2'b10, 8'd0);
    checkOutput("ver_ok_busy", {1'b0, busy}, 2'b01);
    checkOutput("ver_ok_done0", {1'b0, done}, 2'b00);
    tick();
    checkOutput("ver_ok_done1", {1'b0, done}, 2'b01);
    checkOutput("ver_ok_err", {1'b0, err}, 2'b00);
    tick();

    clearPair();
    applyStimulus(OP_CNT_UP, 2'b00, 2'b00, 8'd5);
    checkOutput("up_J0", J, 2'b01);
    checkOutput("up_K0", K, 2'b01);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput($sformatf("up_Q%0d", k), Q, upSeq[k-1]);
      checkOutput($sformatf("up_done%0d", k), {1'b0, done}, (k == 5) ? 2'b01 : 2'b00);
    end
    tick();
    checkOutput("up_idle", {1'b0, cmd_ready}, 2'b01);

    clearPair();
    applyStimulus(OP_CNT_DN, 2'b00, 2'b00, 8'd2);
    checkOutput("dn_J0", J, 2'b11);
    tick();
    checkOutput("dn_Q1", Q, 2'b11);
    checkOutput("dn_J1", J, 2'b01);
    checkOutput("dn_done1", {1'b0, done}, 2'b00);
    tick();
    checkOutput("dn_Q2", Q, 2'b10);
    checkOutput("dn_done2", {1'b0, done}, 2'b01);
    tick();

    applyStimulus(OP_VERIFY, 2'b00, 2'b01, 8'd0);
    tick();
    checkOutput("ver_bad_done", {1'b0, done}, 2'b01);
    checkOutput("ver_bad_err1", {1'b0, err}, 2'b01);
    tick();
    checkOutput("ver_bad_err2", {1'b0, err}, 2'b01);
    tick();
    checkOutput("ver_bad_err3", {1'b0, err}, 2'b01);
    err_clr = 1'b1;
    tick();
    checkOutput("err_cleared", {1'b0, err}, 2'b00);

    applyStimulus(OP_VERIFY, 2'b00, 2'b01, 8'd0);
    tick();
    checkOutput("err_set_wins", {1'b0, err}, 2'b01);
    tick();
    checkOutput("err_clr_after", {1'b0, err}, 2'b00);
    err_clr = 1'b0;

    clearPair();
    applyStimulus(OP_TOGGLE, 2'b01, 2'b00, 8'd3);
    checkOutput("tog_J0", J, 2'b01);
    checkOutput("tog_K0", K, 2'b01);
    tick();
    checkOutput("tog_Q1", Q, 2'b01);
    checkOutput("tog_done1", {1'b0, done}, 2'b00);
    cmd_valid = 1'b1;
    cmd_op    = OP_CLEAR;
    cmd_mask  = 2'b11;
    tick();
    cmd_valid = 1'b0;
    checkOutput("tog_Q2", Q, 2'b00);
    checkOutput("busy_ignore_RD", RD_o, 2'b11);
    checkOutput("tog_done2", {1'b0, done}, 2'b00);
    tick();
    checkOutput("tog_Q3", Q, 2'b01);
    checkOutput("tog_done3", {1'b0, done}, 2'b01);
    tick();
    checkOutput("tog_idle", {1'b0, cmd_ready}, 2'b01);
    checkOutput("no_queue_RD", RD_o, 2'b11);
    checkOutput("no_queue_Q", Q, 2'b01);

    applyStimulus(OP_TOGGLE, 2'b01, 2'b00, 8'd0);
    checkOutput("cnt0_done", {1'b0, done}, 2'b01);
    checkOutput("cnt0_J", J, 2'b00);
    checkOutput("cnt0_K", K, 2'b00);
    tick();
    checkOutput("cnt0_idle", {1'b0, cmd_ready}, 2'b01);
    checkOutput("cnt0_Q", Q, 2'b01);

    applyStimulus(OP_NOP, 2'b00, 2'b00, 8'd0);
    checkOutput("nop_done", {1'b0, done}, 2'b01);
    tick();

    applyStimulus(OP_PRESET, 2'b10, 2'b00, 8'd0);
    checkOutput("pre_SD", SD_o, 2'b01);
    checkOutput("pre_RD", RD_o, 2'b11);
    checkOutput("pre_Q", Q, 2'b11);
    tick();
    checkOutput("pre_done", {1'b0, done}, 2'b01);
    checkOutput("pre_SD_rel", SD_o, 2'b11);
    tick();

    clearPair();
    applyStimulus(OP_CNT_UP, 2'b00, 2'b00, 8'd10);
    tick();
    tick();
    tick();
    #2 RD = 1'b0;
    #1;
    checkOutput("abort_J", J, 2'b00);
    checkOutput("abort_K", K, 2'b00);
    checkOutput("abort_busy", {1'b0, busy}, 2'b00);
    checkOutput("abort_done", {1'b0, done}, 2'b00);
    checkOutput("abort_Q", Q, 2'b11);
    tick();
    checkOutput("abort_done_hold", {1'b0, done}, 2'b00);
    tick();
    checkOutput("abort_Q_hold", Q, 2'b11);
    RD = 1'b1;
    checkOutput("abort_ready", {1'b0, cmd_ready}, 2'b01);
    applyStimulus(OP_NOP, 2'b00, 2'b00, 8'd0);
    checkOutput("post_rst_accept", {1'b0, done}, 2'b01);
    tick();
    checkOutput("post_rst_done_clr", {1'b0, done}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
